// File: rtl/capture_ctrl_if.sv
// Handshake/status bundle between the capture controller and its neighbours.
// CAPT_CNT_EN adds the completed-capture counter signal.
interface capture_ctrl_if #(parameter int AW = 9);
  logic          run;
  logic          wrt_smpl;
  logic          triggered;
  logic [AW-1:0] trig_pos;
  logic          clr_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          set_capture_done;
  logic          capture_done;
  logic [AW-1:0] trace_end;
`ifdef CAPT_CNT_EN
  logic [15:0]   capt_cnt;

  modport master (
    output run, wrt_smpl, triggered, trig_pos, clr_done,
    input  we, waddr, armed, set_capture_done, capture_done, trace_end, capt_cnt
  );
  modport slave (
    input  run, wrt_smpl, triggered, trig_pos, clr_done,
    output we, waddr, armed, set_capture_done, capture_done, trace_end, capt_cnt
  );
`else
  modport master (
    output run, wrt_smpl, triggered, trig_pos, clr_done,
    input  we, waddr, armed, set_capture_done, capture_done, trace_end
  );
  modport slave (
    input  run, wrt_smpl, triggered, trig_pos, clr_done,
    output we, waddr, armed, set_capture_done, capture_done, trace_end
  );
`endif
endinterface

// File: rtl/capture_ctrl.sv
// Capture controller: circular sample-RAM writer with pre/post-trigger counting.
// Optional CAPT_CNT_EN adds a saturating count of completed captures.
module capture_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] waddr, pos_q, smpl_cnt, trig_cnt, trace_end;
    logic          scd, cdone;
    logic          we, armed, final_wr;
    logic [AW-1:0] waddr_nxt, post_lim, tp_clamp;

    // When DEPTH fills the address space the clamp is a no-op.
    generate
        if (DEPTH == (1 << AW)) begin : g_noclamp
            assign tp_clamp = bus.trig_pos;
        end else begin : g_clamp
            assign tp_clamp = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
        end
    endgenerate

    always_comb begin
        we        = (state == RUN) & bus.wrt_smpl;
        armed     = (state == RUN) & (smpl_cnt == pos_q);
        waddr_nxt = (waddr == LAST) ? '0 : waddr + AW'(1);
        post_lim  = LAST - pos_q;
        final_wr  = we & bus.triggered & (trig_cnt == post_lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waddr     <= '0;
            pos_q     <= '0;
            smpl_cnt  <= '0;
            trig_cnt  <= '0;
            trace_end <= '0;
            scd       <= 1'b0;
            cdone     <= 1'b0;
        end else begin
            scd <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state    <= RUN;
                        pos_q    <= tp_clamp;
                        smpl_cnt <= '0;
                        trig_cnt <= '0;
                    end
                end
                RUN: begin
                    if (we) waddr <= waddr_nxt;
                    // Restart takes priority over a coincident final write.
                    if (bus.run) begin
                        pos_q    <= tp_clamp;
                        smpl_cnt <= '0;
                        trig_cnt <= '0;
                    end else if (we) begin
                        if (smpl_cnt != pos_q) smpl_cnt <= smpl_cnt + AW'(1);
                        if (bus.triggered)     trig_cnt <= trig_cnt + AW'(1);
                        if (final_wr) begin
                            state     <= DONE;
                            trace_end <= waddr;
                            scd       <= 1'b1;
                            cdone     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.clr_done) begin
                        state <= IDLE;
                        cdone <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAPT_CNT_EN
    logic [15:0] capt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            capt_cnt <= '0;
        else if (final_wr && !bus.run && capt_cnt != 16'hFFFF)
            capt_cnt <= capt_cnt + 16'd1;
    end

    assign bus.capt_cnt = capt_cnt;
`endif

    assign bus.we               = we;
    assign bus.waddr            = waddr;
    assign bus.armed            = armed;
    assign bus.set_capture_done = scd;
    assign bus.capture_done     = cdone;
    assign bus.trace_end        = trace_end;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed table-driven bench for capture_ctrl at DEPTH=8.
module tb_capture_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk, rst_n;
  int   n_tests, n_fail;

  capture_ctrl_if #(.AW(AW)) bus ();
  capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          run, wrt, trig, clr;
    logic [AW-1:0] tp;
    logic          we;
    logic [AW-1:0] wa;
    logic          arm, scd, cd;
    logic [AW-1:0] te;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic run, wrt, trig, input int tp, input logic clr,
                     input logic we, input int wa, input logic arm, scd, cd, input int te);
    vec_t v;
    v.run = run; v.wrt = wrt; v.trig = trig; v.tp = AW'(tp); v.clr = clr;
    v.we = we; v.wa = AW'(wa); v.arm = arm; v.scd = scd; v.cd = cd; v.te = AW'(te);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic run, wrt, trig, input logic [AW-1:0] tp, input logic clr);
    bus.run = run; bus.wrt_smpl = wrt; bus.triggered = trig; bus.trig_pos = tp; bus.clr_done = clr;
  endtask

  task automatic chk_idle(input string nm, input int idx);
    chk({nm, "_we"},    idx, 16'(bus.we), 16'd0);
    chk({nm, "_armed"}, idx, 16'(bus.armed), 16'd0);
    chk({nm, "_waddr"}, idx, 16'(bus.waddr), 16'd0);
    chk({nm, "_cdone"}, idx, 16'(bus.capture_done), 16'd0);
    chk({nm, "_tend"},  idx, 16'(bus.trace_end), 16'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Capture 1: trig_pos=3, trigger from 5th write, ends at address 0.
    add(1,0,0,3,0, 0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,3,0, 1,i,(i == 3),0,0,0);
    for (int i = 4; i < 9; i++) add(0,1,1,3,0, 1,i % 8,1,0,0,0);
    add(0,1,1,3,0, 0,1,0,1,1,0);   // pulse; we blocked in DONE
    add(0,1,0,3,0, 0,1,0,0,1,0);
    add(1,1,0,3,0, 0,1,0,0,1,0);   // run ignored in DONE
    add(0,1,0,3,0, 0,1,0,0,1,0);
    add(1,0,0,3,1, 0,1,0,0,1,0);   // run & clr together
    add(0,1,0,3,0, 0,1,0,0,0,0);   // IDLE, no new run
    add(0,0,0,3,1, 0,1,0,0,0,0);   // clr in IDLE
    add(0,1,0,3,0, 0,1,0,0,0,0);
    // trig_pos=0 arms immediately; restart to trig_pos=7 gives a single post write.
    add(1,0,0,0,0, 0,1,0,0,0,0);
    add(0,0,0,0,0, 0,1,1,0,0,0);
    add(1,0,0,7,0, 0,1,1,0,0,0);
    for (int i = 1; i < 8; i++) add(0,1,0,7,0, 1,i,0,0,0,0);
    add(0,1,1,7,0, 1,0,1,0,0,0);
    add(0,0,0,7,0, 0,1,0,1,1,0);
    add(0,0,0,7,1, 0,1,0,0,1,0);
    // Restart on final-write cycle: no pulse.
    add(1,0,0,7,0, 0,1,0,0,0,0);
    for (int i = 1; i < 8; i++) add(0,1,0,7,0, 1,i,0,0,0,0);
    add(1,1,1,7,0, 1,0,1,0,0,0);
    add(0,0,0,7,0, 0,1,0,0,0,0);
    // Capture 3 via restart, trig_pos=2, ends at address 1.
    add(1,0,0,2,0, 0,1,0,0,0,0);
    add(0,1,0,2,0, 1,1,0,0,0,0);
    add(0,1,0,2,0, 1,2,0,0,0,0);
    add(0,1,0,2,0, 1,3,1,0,0,0);
    for (int i = 4; i < 10; i++) add(0,1,1,2,0, 1,i % 8,1,0,0,0);
    add(0,0,0,2,0, 0,2,0,1,1,1);
    add(0,0,0,2,0, 0,2,0,0,1,1);

    @(negedge clk); #1;
    chk_idle("reset", 0);
    chk("reset_scd", 0, 16'(bus.set_capture_done), 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].wrt, tbl[i].trig, tbl[i].tp, tbl[i].clr);
      #1;
      chk("we",    i, 16'(bus.we),               16'(tbl[i].we));
      chk("waddr", i, 16'(bus.waddr),            16'(tbl[i].wa));
      chk("armed", i, 16'(bus.armed),            16'(tbl[i].arm));
      chk("scd",   i, 16'(bus.set_capture_done), 16'(tbl[i].scd));
      chk("cdone", i, 16'(bus.capture_done),     16'(tbl[i].cd));
      chk("tend",  i, 16'(bus.trace_end),        16'(tbl[i].te));
    end

`ifdef CAPT_CNT_EN
    chk("capt_cnt", 0, bus.capt_cnt, 16'd3);
`endif

    // Reset mid-capture with we active.
    @(negedge clk); drive(0, 0, 0, 0, 1);
    @(negedge clk); drive(1, 0, 0, 3, 0);
    @(negedge clk); drive(0, 1, 0, 3, 0);
    #1;
    chk("pre_rst_we", 0, 16'(bus.we), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async", 0);
    @(negedge clk); #1;
    chk_idle("rst_held", 0);
`ifdef CAPT_CNT_EN
    chk("rst_capt_cnt", 0, bus.capt_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_idle("rst_idle", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
